// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one memory port between instruction fetch and the
//            MEM-stage data access. Data wins ties, one transaction is in
//            flight at a time, and the pipeline advances only when every
//            outstanding request has been served.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    // instruction fetch side
    input  logic        i_read,
    input  logic [15:0] i_addr,
    output logic [15:0] i_rdata,
    output logic        i_resp,
    // data side
    input  logic        d_read,
    input  logic        d_write,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    input  logic [1:0]  d_wmask,
    output logic [15:0] d_rdata,
    output logic        d_resp,
    // shared physical memory port
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [15:0] pmem_addr,
    output logic [15:0] pmem_wdata,
    output logic [1:0]  pmem_wmask,
    input  logic [15:0] pmem_rdata,
    input  logic        pmem_resp,
    // pipeline control
    output logic        pipe_advance,
    output logic [15:0] stall_count
);

    localparam logic [15:0] C_STALL_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_D_BUSY = 2'd1,
        ST_I_BUSY = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_i_done;
    logic        r_d_done;
    logic        w_i_need;
    logic        w_d_need;
    logic        w_pipe_advance;
    logic        w_d_complete;
    logic        w_i_complete;

    logic        r_pmem_read;
    logic        r_pmem_write;
    logic [15:0] r_pmem_addr;
    logic [15:0] r_pmem_wdata;
    logic [1:0]  r_pmem_wmask;

    logic [15:0] r_i_rdata;
    logic [15:0] r_d_rdata;
    logic        r_i_resp;
    logic        r_d_resp;
    logic [15:0] r_stall_count;

    // A requester still needs service until its done flag is set this stage
    assign w_i_need     = i_read & ~r_i_done;
    assign w_d_need     = (d_read | d_write) & ~r_d_done;
    assign w_d_complete = (r_state == ST_D_BUSY) & pmem_resp;
    assign w_i_complete = (r_state == ST_I_BUSY) & pmem_resp;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state selection; pipe_advance only in IDLE with nothing pending
    always_comb begin
        w_state_next   = r_state;
        w_pipe_advance = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_d_need) begin
                    w_state_next = ST_D_BUSY;
                end else if (w_i_need) begin
                    w_state_next = ST_I_BUSY;
                end else begin
                    w_pipe_advance = 1'b1;
                end
            end
            ST_D_BUSY, ST_I_BUSY: begin
                if (pmem_resp) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Latch the granted request onto the memory port; hold it until resp
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_pmem_addr  <= 16'h0000;
            r_pmem_wdata <= 16'h0000;
            r_pmem_wmask <= 2'b00;
        end else if (r_state == ST_IDLE) begin
            if (w_d_need) begin
                // read+write together is treated as a store
                r_pmem_read  <= ~d_write;
                r_pmem_write <= d_write;
                r_pmem_addr  <= d_addr;
                r_pmem_wdata <= d_wdata;
                r_pmem_wmask <= d_wmask;
            end else if (w_i_need) begin
                r_pmem_read  <= 1'b1;
                r_pmem_write <= 1'b0;
                r_pmem_addr  <= i_addr;
                r_pmem_wdata <= 16'h0000;
                r_pmem_wmask <= 2'b00;
            end
        end else if (pmem_resp) begin
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
        end
    end

    // Capture read data and issue one-cycle completion pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_rdata <= 16'h0000;
            r_d_rdata <= 16'h0000;
            r_i_resp  <= 1'b0;
            r_d_resp  <= 1'b0;
        end else begin
            r_i_resp <= w_i_complete;
            r_d_resp <= w_d_complete;
            if (w_d_complete && !r_pmem_write) begin
                r_d_rdata <= pmem_rdata;
            end
            if (w_i_complete) begin
                r_i_rdata <= pmem_rdata;
            end
        end
    end

    // Done flags: set on completion, cleared when the pipeline advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
        end else if (w_pipe_advance) begin
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
        end else begin
            if (w_i_complete) begin
                r_i_done <= 1'b1;
            end
            if (w_d_complete) begin
                r_d_done <= 1'b1;
            end
        end
    end

    // Saturating count of cycles in which the pipeline is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= 16'h0000;
        end else if (!w_pipe_advance && (r_stall_count != C_STALL_MAX)) begin
            r_stall_count <= r_stall_count + 16'h0001;
        end
    end

    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_addr    = r_pmem_addr;
    assign pmem_wdata   = r_pmem_wdata;
    assign pmem_wmask   = r_pmem_wmask;
    assign i_rdata      = r_i_rdata;
    assign d_rdata      = r_d_rdata;
    assign i_resp       = r_i_resp;
    assign d_resp       = r_d_resp;
    assign pipe_advance = w_pipe_advance;
    assign stall_count  = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter. Inputs change and
//            outputs are sampled around the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_read;
    logic [15:0] i_addr;
    logic [15:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [1:0]  d_wmask;
    logic [15:0] d_rdata;
    logic        d_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_addr;
    logic [15:0] pmem_wdata;
    logic [1:0]  pmem_wmask;
    logic [15:0] pmem_rdata;
    logic        pmem_resp;
    logic        pipe_advance;
    logic [15:0] stall_count;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_read       (i_read),
        .i_addr       (i_addr),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_wmask      (d_wmask),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_addr    (pmem_addr),
        .pmem_wdata   (pmem_wdata),
        .pmem_wmask   (pmem_wmask),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .pipe_advance (pipe_advance),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; i_read = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;

        // ---- reset values, no requests ----
        @(negedge clk); #1;
        chk("rst_pmem_read",  {15'd0, pmem_read},  16'h0000);
        chk("rst_pmem_write", {15'd0, pmem_write}, 16'h0000);
        chk("rst_pmem_addr",  pmem_addr,  16'h0000);
        chk("rst_pmem_wdata", pmem_wdata, 16'h0000);
        chk("rst_pmem_wmask", {14'd0, pmem_wmask}, 16'h0000);
        chk("rst_i_rdata",    i_rdata,    16'h0000);
        chk("rst_d_rdata",    d_rdata,    16'h0000);
        chk("rst_resp",       {14'd0, i_resp, d_resp}, 16'h0000);
        chk("rst_stall",      stall_count, 16'h0000);
        chk("rst_adv_idle",   {15'd0, pipe_advance}, 16'h0001);
        // a request during reset keeps pipe_advance low
        i_read = 1'b1; #1;
        chk("rst_adv_req",    {15'd0, pipe_advance}, 16'h0000);
        i_read = 1'b0;
        @(negedge clk); rst_n = 1'b1; #1;

        // ---- fetch only, resp on the 3rd busy cycle ----
        @(negedge clk); i_read = 1'b1; i_addr = 16'h0040; #1;
        chk("f_adv_idle", {15'd0, pipe_advance}, 16'h0000);
        @(negedge clk); #1;
        chk("f_pmem_read",  {15'd0, pmem_read},  16'h0001);
        chk("f_pmem_write", {15'd0, pmem_write}, 16'h0000);
        chk("f_pmem_addr",  pmem_addr, 16'h0040);
        chk("f_pmem_wmask", {14'd0, pmem_wmask}, 16'h0000);
        chk("f_stall1", stall_count, 16'h0001);
        @(negedge clk); #1;
        chk("f_busy2_read", {15'd0, pmem_read}, 16'h0001);
        chk("f_busy2_adv",  {15'd0, pipe_advance}, 16'h0000);
        @(negedge clk); pmem_resp = 1'b1; pmem_rdata = 16'h1234; #1;
        chk("f_busy3_addr", pmem_addr, 16'h0040);
        @(negedge clk); pmem_resp = 1'b0; pmem_rdata = 16'h0000; #1;
        chk("f_i_resp",  {15'd0, i_resp}, 16'h0001);
        chk("f_i_rdata", i_rdata, 16'h1234);
        chk("f_rd_drop", {15'd0, pmem_read}, 16'h0000);
        chk("f_adv",     {15'd0, pipe_advance}, 16'h0001);
        chk("f_stall4",  stall_count, 16'h0004);
        @(negedge clk); i_read = 1'b0; #1;
        chk("f_i_resp_off", {15'd0, i_resp}, 16'h0000);
        chk("f_stall_hold", stall_count, 16'h0004);

        // ---- simultaneous fetch and load: data first ----
        @(negedge clk); i_read = 1'b1; i_addr = 16'h0040; d_read = 1'b1; d_addr = 16'h3000; #1;
        chk("s_adv0", {15'd0, pipe_advance}, 16'h0000);
        @(negedge clk); #1;
        chk("s_d_addr", pmem_addr, 16'h3000);
        chk("s_d_read", {15'd0, pmem_read}, 16'h0001);
        pmem_resp = 1'b1; pmem_rdata = 16'hA5A5;
        @(negedge clk); pmem_resp = 1'b0; #1;
        chk("s_d_resp",  {15'd0, d_resp}, 16'h0001);
        chk("s_i_resp0", {15'd0, i_resp}, 16'h0000);
        chk("s_d_rdata", d_rdata, 16'hA5A5);
        chk("s_adv_mid", {15'd0, pipe_advance}, 16'h0000);
        @(negedge clk); #1;
        chk("s_i_addr",  pmem_addr, 16'h0040);
        chk("s_i_read",  {15'd0, pmem_read}, 16'h0001);
        chk("s_d_resp1", {15'd0, d_resp}, 16'h0000);
        pmem_resp = 1'b1; pmem_rdata = 16'h5678;
        @(negedge clk); pmem_resp = 1'b0; #1;
        chk("s_i_resp",  {15'd0, i_resp}, 16'h0001);
        chk("s_i_rdata", i_rdata, 16'h5678);
        chk("s_adv",     {15'd0, pipe_advance}, 16'h0001);
        chk("s_stall",   stall_count, 16'h0008);
        i_read = 1'b0; d_read = 1'b0;

        // ---- store ----
        @(negedge clk); d_write = 1'b1; d_addr = 16'h3002; d_wdata = 16'hBEEF; d_wmask = 2'b01; #1;
        @(negedge clk); #1;
        chk("w_write", {15'd0, pmem_write}, 16'h0001);
        chk("w_read",  {15'd0, pmem_read},  16'h0000);
        chk("w_addr",  pmem_addr,  16'h3002);
        chk("w_wdata", pmem_wdata, 16'hBEEF);
        chk("w_wmask", {14'd0, pmem_wmask}, 16'h0001);
        pmem_resp = 1'b1; pmem_rdata = 16'hDEAD;
        @(negedge clk); pmem_resp = 1'b0; #1;
        chk("w_d_resp",  {15'd0, d_resp}, 16'h0001);
        chk("w_d_rdata", d_rdata, 16'hA5A5);
        chk("w_adv",     {15'd0, pipe_advance}, 16'h0001);
        chk("w_stall",   stall_count, 16'h000A);
        d_write = 1'b0;

        // ---- read and write together behave as a store ----
        @(negedge clk); d_read = 1'b1; d_write = 1'b1; d_addr = 16'h3004; d_wdata = 16'h1111; d_wmask = 2'b11; #1;
        @(negedge clk); #1;
        chk("rw_write", {15'd0, pmem_write}, 16'h0001);
        chk("rw_read",  {15'd0, pmem_read},  16'h0000);
        chk("rw_wmask", {14'd0, pmem_wmask}, 16'h0003);
        pmem_resp = 1'b1; pmem_rdata = 16'hCAFE;
        @(negedge clk); pmem_resp = 1'b0; #1;
        chk("rw_d_rdata", d_rdata, 16'hA5A5);
        chk("rw_stall",   stall_count, 16'h000C);
        d_read = 1'b0; d_write = 1'b0;

        // ---- inputs changing during busy are ignored ----
        @(negedge clk); d_read = 1'b1; d_addr = 16'h3000; #1;
        @(negedge clk); d_addr = 16'h4000; #1;
        chk("c_addr1", pmem_addr, 16'h3000);
        @(negedge clk); #1;
        chk("c_addr2", pmem_addr, 16'h3000);
        pmem_resp = 1'b1; pmem_rdata = 16'h0BAD;
        @(negedge clk); pmem_resp = 1'b0; #1;
        chk("c_d_rdata", d_rdata, 16'h0BAD);
        chk("c_stall",   stall_count, 16'h000F);
        d_read = 1'b0;

        // ---- pmem_resp while idle is ignored ----
        @(negedge clk); pmem_resp = 1'b1; pmem_rdata = 16'hFFFF; #1;
        @(negedge clk); pmem_resp = 1'b0; #1;
        chk("ir_resp",    {14'd0, i_resp, d_resp}, 16'h0000);
        chk("ir_d_rdata", d_rdata, 16'h0BAD);
        chk("ir_i_rdata", i_rdata, 16'h5678);

        // ---- reset in the middle of a data transaction ----
        @(negedge clk); d_read = 1'b1; d_addr = 16'h3000; #1;
        @(negedge clk); #1;
        chk("r_busy", {15'd0, pmem_read}, 16'h0001);
        rst_n = 1'b0; d_read = 1'b0; #1;
        chk("r_read",    {15'd0, pmem_read}, 16'h0000);
        chk("r_addr",    pmem_addr, 16'h0000);
        chk("r_stall",   stall_count, 16'h0000);
        chk("r_d_rdata", d_rdata, 16'h0000);
        @(negedge clk); rst_n = 1'b1; pmem_resp = 1'b1; pmem_rdata = 16'h7777; #1;
        @(negedge clk); pmem_resp = 1'b0; #1;
        chk("r_no_resp",  {14'd0, i_resp, d_resp}, 16'h0000);
        chk("r_d_rdata2", d_rdata, 16'h0000);
        chk("r_stall2",   stall_count, 16'h0000);
        chk("r_adv",      {15'd0, pipe_advance}, 16'h0001);

        // ---- stall counter saturation ----
        @(negedge clk); i_read = 1'b1; i_addr = 16'h0100; #1;
        repeat (65534) @(negedge clk);
        #1;
        chk("sat_fffe", stall_count, 16'hFFFE);
        @(negedge clk); #1;
        chk("sat_ffff", stall_count, 16'hFFFF);
        repeat (4465) @(negedge clk);
        #1;
        chk("sat_hold", stall_count, 16'hFFFF);
        chk("sat_read", {15'd0, pmem_read}, 16'h0001);
        i_read = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: i_read  in  1  fetch request; i_addr  in  16  fetch address; i_rdata  out  16  fetch data; i_resp  out  1  fetch complete.
REQ-003 SHALL have ports: d_read  in  1  MEM-stage load; d_write  in  1  MEM-stage store; d_addr  in  16  data address; d_wdata  in  16  store data; d_wmask  in  2  byte enables; d_rdata  out  16  load data; d_resp  out  1  data complete.
REQ-004 SHALL have ports: pmem_read  out  1; pmem_write  out  1; pmem_addr  out  16; pmem_wdata  out  16; pmem_wmask  out  2; pmem_rdata  in  16; pmem_resp  in  1 (single shared memory port).
REQ-005 SHALL have ports: pipe_advance  out  1  load enable for all pipeline registers; stall_count  out  16  stalled-cycle counter.

Function
REQ-006 SHALL implement FSM states IDLE, D_BUSY, I_BUSY; one request on pmem at a time.
REQ-007 SHALL keep flags i_done, d_done; i_need = i_read & ~i_done; d_need = (d_read|d_write) & ~d_done.
REQ-008 IDLE: d_need -> D_BUSY; else i_need -> I_BUSY; else stay IDLE and assert pipe_advance that cycle (combinational from state/flags).
REQ-009 Data SHALL have priority over fetch when both needed in the same IDLE cycle.
REQ-010 On IDLE->BUSY, the selected requester's addr/wdata/wmask and read/write kind SHALL be latched into pmem_* registers; pmem_* stable throughout BUSY.
REQ-011 pmem_read/pmem_write SHALL be asserted only in D_BUSY/I_BUSY, never both; I_BUSY always read, wmask 2'b00.
REQ-012 d_read and d_write both high SHALL be treated as a write.
REQ-013 In BUSY on pmem_resp=1: capture pmem_rdata into i_rdata or d_rdata register, pulse i_resp or d_resp for exactly one cycle (next cycle), set matching done flag, return to IDLE.
REQ-014 i_rdata/d_rdata SHALL hold last captured value until next capture; d_rdata unchanged on writes.
REQ-015 pipe_advance=1 SHALL clear i_done and d_done at that rising edge.
REQ-016 Minimum latency per single request: 1 IDLE cycle + BUSY cycles through pmem_resp + 1 IDLE cycle with pipe_advance; both requests: sequential, data first.
REQ-017 Requester inputs changing or dropping during BUSY SHALL be ignored; transaction completes with latched values.
REQ-018 pmem_resp while IDLE SHALL be ignored.
REQ-019 stall_count SHALL increment by 1 every cycle pipe_advance=0, saturate at 16'hFFFF, never wrap.
REQ-020 No requests at all SHALL yield pipe_advance=1 every cycle in IDLE.

Reset
REQ-021 rst_n=0 SHALL immediately force state IDLE, clear done flags, pmem_read/pmem_write/i_resp/d_resp=0, pmem_addr/wdata/wmask=0, i_rdata/d_rdata=0, stall_count=0.
REQ-022 Reset asserted mid-BUSY SHALL abandon the transaction with no resp pulse; any later pmem_resp in IDLE ignored.
REQ-023 pipe_advance SHALL be 1 during reset only if combinationally derived conditions hold (no requests); otherwise 0.

Verification
REQ-024 Fetch only: i_read=1, i_addr=16'h0040, pmem_resp after 3 cycles with rdata 16'h1234 -> pmem_read with addr 0040, i_rdata=1234, one i_resp pulse, one pipe_advance pulse, stall_count=4.
REQ-025 Simultaneous: i_read=1 (0x0040), d_read=1 (0x3000) -> pmem serves 3000 first then 0040, d_resp before i_resp, single pipe_advance after both.
REQ-026 Store: d_write=1, d_addr=16'h3002, d_wdata=16'hBEEF, d_wmask=2'b01 -> pmem_write with identical values, d_rdata unchanged, no pmem_read.
REQ-027 Input change mid-BUSY: change d_addr from 3000 to 4000 during D_BUSY -> pmem_addr stays 3000 until pmem_resp.
REQ-028 Reset mid-D_BUSY then pmem_resp=1 in IDLE -> no d_resp, all outputs at reset values, stall_count=0.
REQ-029 Saturation: hold i_read=1 with no pmem_resp for 70000 cycles -> stall_count sticks at 16'hFFFF.
